// File: rtl/expr_checker_if.sv
// expr_checker_if
// Groups the character stream and result signals of expr_checker.
//   in     : ASCII character presented to the checker (driven by master)
//   out    : accepted sequence is a complete valid expression
//   err    : sequence has become invalid (sticky until reset)
//   result : value of the expression so far, modulo 2^RES_W
//   op_cnt : saturating count of accepted operators
// Modports: master (byte source side), slave (checker side).
interface expr_checker_if #(
  parameter int RES_W = 16,
  parameter int CNT_W = 8
);
  logic [7:0]       in;
  logic             out;
  logic             err;
  logic [RES_W-1:0] result;
  logic [CNT_W-1:0] op_cnt;

  modport master (output in, input out, input err, input result, input op_cnt);
  modport slave  (input in, output out, output err, output result, output op_cnt);
endinterface

// File: rtl/expr_checker.sv
// expr_checker
// Serial recognizer/evaluator for ASCII expressions of the form
// digit (op digit)*, one character per clock, '*' binding tighter than '+'.
// Ports:
//   clk : rising-edge clock
//   clr : asynchronous active-low reset
//   bus : expr_checker_if slave (in, out, err, result, op_cnt)
// Optional feature: define EXPR_MINUS_EN to accept '-' as an operator.
module expr_checker #(
  parameter int RES_W = 16,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         clr,
  expr_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_NUM, S_OP, S_ERR} state_e;

  state_e           state_q, state_d;
  logic [RES_W-1:0] sum_q, sum_d;
  logic [RES_W-1:0] prod_q, prod_d;
  logic             pm_q, pm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef EXPR_MINUS_EN
  logic             sg_q, sg_d;
`endif

  logic             is_digit, is_add, is_mul, is_sub, is_op;
  logic [RES_W-1:0] digit_val;

  // Character classification; the low nibble of '0'..'9' is the digit value.
  always_comb begin
    is_digit  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_add    = (bus.in == 8'h2B);
    is_mul    = (bus.in == 8'h2A);
`ifdef EXPR_MINUS_EN
    is_sub    = (bus.in == 8'h2D);
`else
    is_sub    = 1'b0;
`endif
    is_op     = is_add | is_mul | is_sub;
    digit_val = RES_W'(bus.in[3:0]);
  end

  // State and evaluation registers. A completed term is folded into sum
  // only when the next additive operator arrives, so prod always holds the
  // term currently being multiplied up.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      prod_q  <= '0;
      pm_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef EXPR_MINUS_EN
      sg_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      pm_q    <= pm_d;
      cnt_q   <= cnt_d;
`ifdef EXPR_MINUS_EN
      sg_q    <= sg_d;
`endif
    end
  end

  // Next-state and evaluation update. Any transition into S_ERR leaves the
  // evaluation registers at their defaults, which freezes them.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    pm_d    = pm_q;
    cnt_d   = cnt_q;
`ifdef EXPR_MINUS_EN
    sg_d    = sg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          state_d = S_NUM;
          sum_d   = '0;
          prod_d  = digit_val;
        end else begin
          state_d = S_ERR;
        end
      end
      S_NUM: begin
        if (is_op) begin
          state_d = S_OP;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          if (is_mul) begin
            pm_d = 1'b1;
          end else begin
            sum_d = sum_q + prod_q;
            pm_d  = 1'b0;
`ifdef EXPR_MINUS_EN
            sg_d  = is_sub;
`endif
          end
        end else begin
          state_d = S_ERR;
        end
      end
      S_OP: begin
        if (is_digit) begin
          state_d = S_NUM;
          if (pm_q) begin
            prod_d = prod_q * digit_val;
          end else begin
`ifdef EXPR_MINUS_EN
            prod_d = sg_q ? ((~digit_val) + 1'b1) : digit_val;
`else
            prod_d = digit_val;
`endif
          end
        end else begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_ERR;
    endcase
  end

  // Moore decodes only; nothing here depends combinationally on bus.in.
  assign bus.out    = (state_q == S_NUM);
  assign bus.err    = (state_q == S_ERR);
  assign bus.result = sum_q + prod_q;
  assign bus.op_cnt = cnt_q;

endmodule

// File: tb/tb_expr_checker.sv
// tb_expr_checker
// Randomized and directed character streams for expr_checker. Expected
// responses come from a token-list reference model and are queued; a
// monitor pops and compares one entry after every clock edge that sampled
// a character.
module tb_expr_checker;

  localparam int RW = 8;
  localparam int CW = 4;

  typedef struct {
    logic          out;
    logic          err;
    logic [RW-1:0] result;
    logic [CW-1:0] op_cnt;
  } exp_t;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  exp_t       expQ[$];
  logic [7:0] hist[$];
  bit         bad;

  expr_checker_if #(.RES_W(RW), .CNT_W(CW)) bus ();

  expr_checker #(.RES_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit isDig(logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit isOp(logic [7:0] c);
`ifdef EXPR_MINUS_EN
    return (c == 8'h2B) || (c == 8'h2A) || (c == 8'h2D);
`else
    return (c == 8'h2B) || (c == 8'h2A);
`endif
  endfunction

  // Evaluates the accepted token list as a sum of signed products.
  function automatic int evalHist();
    int total = 0;
    int term;
    term = int'(hist[0]) - 48;
    for (int i = 1; i + 1 < hist.size(); i += 2) begin
      int d = int'(hist[i+1]) - 48;
      if (hist[i] == 8'h2A) begin
        term = term * d;
      end else begin
        total = total + term;
        term  = (hist[i] == 8'h2D) ? -d : d;
      end
    end
    return total + term;
  endfunction

  function automatic exp_t modelExpect();
    exp_t e;
    int   ops;
    int   v;
    e.err    = bad;
    e.out    = !bad && (hist.size() > 0) && isDig(hist[hist.size()-1]);
    ops      = hist.size() / 2;
    e.op_cnt = (ops > 15) ? 4'hF : CW'(ops);
    v        = e.out ? evalHist() : 0;
    e.result = RW'(v);
    return e;
  endfunction

  function automatic void modelStep(logic [7:0] c);
    bit ok;
    if (!bad) begin
      if (hist.size() == 0 || isOp(hist[hist.size()-1])) ok = isDig(c);
      else ok = isOp(c);
      if (ok) hist.push_back(c);
      else bad = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one character for the next rising edge, releasing reset if held.
  task automatic applyStimulus(input logic [7:0] c);
    @(negedge clk);
    clr    = 1'b1;
    bus.in = c;
    modelStep(c);
    expQ.push_back(modelExpect());
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_out"},    32'(bus.out),    32'd0);
    checkOutput({tag, "_err"},    32'(bus.err),    32'd0);
    checkOutput({tag, "_result"}, 32'(bus.result), 32'd0);
    checkOutput({tag, "_opcnt"},  32'(bus.op_cnt), 32'd0);
  endtask

  // Asserts reset between edges; it stays low until the next character.
  task automatic applyReset();
    @(negedge clk);
    clr = 1'b0;
    hist.delete();
    bad = 1'b0;
    #1;
    checkReset("reset");
  endtask

  task automatic applyString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(8'(s[i]));
  endtask

  // Monitor: one queued expectation per sampled character.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("out",    32'(bus.out),    32'(e.out));
        checkOutput("err",    32'(bus.err),    32'(e.err));
        checkOutput("op_cnt", 32'(bus.op_cnt), 32'(e.op_cnt));
        if (e.out) checkOutput("result", 32'(bus.result), 32'(e.result));
      end
    end
  end

  initial begin
    bit         wantDigit;
    int         len;
    logic [7:0] c;
    checks = 0;
    errors = 0;
    bad    = 1'b0;
    bus.in = 8'h00;
    clr    = 1'b0;
    #2;
    checkReset("por");

    applyReset(); applyString("1+2*3");
    applyReset(); applyString("12"); applyString("3+4");
    applyReset(); applyString("+");
    applyReset(); applyString("9*9*9");
    applyReset(); applyString("7-2*3");
    applyReset(); applyString("9*");
    applyString("8");
    applyReset(); applyString("1+1+1+1+1+1+1+1+1+1+1+1+1+1+1+1+1+1+1+1");

    // Asynchronous reset in the middle of a clock period.
    applyReset(); applyString("1+2");
    @(posedge clk);
    #3;
    clr = 1'b0;
    hist.delete();
    bad = 1'b0;
    #1;
    checkReset("async");
    applyString("5");

    // Mostly well-formed random streams with occasional noise bytes.
    for (int s = 0; s < 30; s++) begin
      applyReset();
      len       = $urandom_range(1, 30);
      wantDigit = 1'b1;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 24) == 0) begin
          c = 8'($urandom_range(0, 255));
        end else if (wantDigit) begin
          c = 8'h30 + 8'($urandom_range(0, 9));
        end else begin
          case ($urandom_range(0, 5))
            0, 1, 2: c = 8'h2B;
            3, 4:    c = 8'h2A;
            default: c = 8'h2D;
          endcase
        end
        wantDigit = !wantDigit;
        applyStimulus(c);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
